// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - Edge-capturing pending latch with masked snapshot handshake for an 8-input priority encoder
//
// Optional build macro: IRQ_PENDING_LATCH_SYNC_EN
//   defined   : a 2-flop synchronizer per request line precedes edge detection,
//               irq_in may be asynchronous, edge-to-snapshot latency is 4 clocks.
//   undefined : irq_in feeds edge detection directly, latency is 2 clocks.

module irq_pending_latch #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     irq_in,
    input  logic [N-1:0]     mask,
    input  logic             ack_valid,
    input  logic [IDX_W-1:0] ack_idx,
    input  logic             clr_ovf,
    output logic [N-1:0]     pend_out,
    output logic             irq_req,
    output logic             ovf
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_t;

    // Request lines as seen by the edge detector
    logic [N-1:0] irq_s;

`ifdef IRQ_PENDING_LATCH_SYNC_EN
    logic [N-1:0] sync1_q;
    logic [N-1:0] sync2_q;

    // Two-stage synchronizer; both stages clear on reset so no spurious edge is seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    logic [N-1:0] irq_dly_q;
    logic [N-1:0] pending_q;
    logic [N-1:0] pending_d;
    logic         ovf_q;
    logic         ovf_d;
    logic [N-1:0] pend_out_q;
    logic [N-1:0] pend_out_d;
    logic         irq_req_q;
    logic         irq_req_d;
    state_t       state_q;
    state_t       state_d;

    logic [N-1:0] rise;
    logic [N-1:0] ack_onehot;
    logic         ack_in_range;
    logic         ack_accept;
    logic [N-1:0] clr_vec;
    logic [N-1:0] masked_pending;

    // Rising edges: the delayed copy resets to 0, so a line already high at
    // reset release is treated as a fresh edge on the first clock.
    assign rise = irq_s & ~irq_dly_q;

    // One-hot of the acknowledged index; an out-of-range index shifts out to zero
    assign ack_onehot   = {{(N-1){1'b0}}, 1'b1} << ack_idx;
    assign ack_in_range = (32'(ack_idx) < N);

    // Only an acknowledge naming a bit of the frozen snapshot is accepted
    assign ack_accept = (state_q == ST_WAIT_ACK) && ack_valid && ack_in_range
                        && ((pend_out_q & ack_onehot) != '0);

    assign clr_vec        = ack_accept ? ack_onehot : '0;
    assign masked_pending = pending_q & mask;

    // Pending update: a new edge on a line wins over its clear in the same cycle
    always_comb begin
        pending_d = (pending_q & ~clr_vec) | rise;
    end

    // Sticky overflow: an edge on a line that stays pending outranks clr_ovf
    always_comb begin
        ovf_d = ovf_q;
        if ((rise & pending_q & ~clr_vec) != '0) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Snapshot handshake: take a masked snapshot in IDLE, hold it frozen until accepted
    always_comb begin
        state_d    = state_q;
        pend_out_d = pend_out_q;
        irq_req_d  = irq_req_q;
        case (state_q)
            ST_IDLE: begin
                if (masked_pending != '0) begin
                    pend_out_d = masked_pending;
                    irq_req_d  = 1'b1;
                    state_d    = ST_WAIT_ACK;
                end else begin
                    pend_out_d = '0;
                    irq_req_d  = 1'b0;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_accept) begin
                    pend_out_d = '0;
                    irq_req_d  = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                pend_out_d = '0;
                irq_req_d  = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops everything including any pending requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_dly_q  <= '0;
            pending_q  <= '0;
            ovf_q      <= 1'b0;
            pend_out_q <= '0;
            irq_req_q  <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            irq_dly_q  <= irq_s;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
            pend_out_q <= pend_out_d;
            irq_req_q  <= irq_req_d;
            state_q    <= state_d;
        end
    end

    assign pend_out = pend_out_q;
    assign irq_req  = irq_req_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb/tb_irq_pending_latch.sv - Scoreboard bench for irq_pending_latch with directed and random stimulus

module tb_irq_pending_latch;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     irq_in;
    logic [N-1:0]     mask;
    logic             ack_valid;
    logic [IDX_W-1:0] ack_idx;
    logic             clr_ovf;
    logic [N-1:0]     pend_out;
    logic             irq_req;
    logic             ovf;

    irq_pending_latch #(.N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .mask      (mask),
        .ack_valid (ack_valid),
        .ack_idx   (ack_idx),
        .clr_ovf   (clr_ovf),
        .pend_out  (pend_out),
        .irq_req   (irq_req),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] p;
        logic         r;
        logic         o;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: per-line pending set, last seen level, and the
    // currently offered snapshot (empty snapshot means nothing is offered).
    bit           m_pend [N];
    bit           m_prev [N];
    bit           m_s1   [N];
    bit           m_s2   [N];
    logic [N-1:0] m_snap;
    bit           m_ovf;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_prev[i] = 0;
            m_s1[i]   = 0;
            m_s2[i]   = 0;
        end
        m_snap = '0;
        m_ovf  = 0;
    endtask

    // Apply one cycle of inputs at the falling edge and record what the
    // outputs must be after the next rising edge.
    task automatic step(input logic [N-1:0] irq, input logic [N-1:0] msk,
                        input logic av, input int ai, input logic co);
        bit           seen [N];
        bit           accept;
        bit           ovf_ev;
        logic [N-1:0] offer;
        exp_t         e;
        @(negedge clk);
        irq_in    = irq;
        mask      = msk;
        ack_valid = av;
        ack_idx   = IDX_W'(ai);
        clr_ovf   = co;

        for (int i = 0; i < N; i++) begin
`ifdef IRQ_PENDING_LATCH_SYNC_EN
            seen[i] = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = irq[i];
`else
            seen[i] = irq[i];
`endif
        end

        accept = (m_snap != '0) && av && (ai < N) && m_snap[ai];

        offer = '0;
        for (int i = 0; i < N; i++)
            if (m_pend[i] && msk[i]) offer[i] = 1'b1;

        ovf_ev = 0;
        for (int i = 0; i < N; i++) begin
            bit edge_i;
            bit cleared;
            edge_i  = seen[i] && !m_prev[i];
            cleared = accept && (ai == i);
            if (edge_i && m_pend[i] && !cleared) ovf_ev = 1;
            m_pend[i] = edge_i || (m_pend[i] && !cleared);
            m_prev[i] = seen[i];
        end

        if (ovf_ev)  m_ovf = 1;
        else if (co) m_ovf = 0;

        if (m_snap != '0) begin
            if (accept) m_snap = '0;
        end else begin
            m_snap = offer;
        end

        e.p = m_snap;
        e.r = (m_snap != '0);
        e.o = m_ovf;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, mask, 1'b0, 0, 1'b0);
    endtask

    // Monitor: after every rising edge that has an expectation queued, compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_pend_out", pend_out, e.p);
                check("sb_irq_req", {{(N-1){1'b0}}, irq_req}, {{(N-1){1'b0}}, e.r});
                check("sb_ovf", {{(N-1){1'b0}}, ovf}, {{(N-1){1'b0}}, e.o});
            end
        end
    end

    initial begin
        logic [N-1:0] rirq;
        logic [N-1:0] rmask;
        int           ai;
        logic         av;

        rst_n     = 1'b0;
        irq_in    = '0;
        mask      = 8'hFF;
        ack_valid = 1'b0;
        ack_idx   = '0;
        clr_ovf   = 1'b0;
        model_reset();
        #1;
        check("reset_pend_out", pend_out, 8'h00);
        check("reset_irq_req", {7'b0, irq_req}, 8'h00);
        check("reset_ovf", {7'b0, ovf}, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single pulse on line 5 is offered two clocks after it rises
        step(8'h20, 8'hFF, 1'b0, 0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 0, 1'b0);
        @(negedge clk);
        check("lat_pend_out", pend_out, 8'h20);
        check("lat_irq_req", {7'b0, irq_req}, 8'h01);

        // New edge while waiting leaves the snapshot frozen
        step(8'h80, 8'hFF, 1'b0, 0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 0, 1'b0);
        @(negedge clk);
        check("frozen_pend_out", pend_out, 8'h20);
        step(8'h00, 8'hFF, 1'b1, 5, 1'b0);
        @(negedge clk);
        check("ack_gap_irq_req", {7'b0, irq_req}, 8'h00);
        step(8'h00, 8'hFF, 1'b0, 0, 1'b0);
        @(negedge clk);
        check("reoffer_pend_out", pend_out, 8'h80);
        check("reoffer_irq_req", {7'b0, irq_req}, 8'h01);
        step(8'h00, 8'hFF, 1'b1, 7, 1'b0);
        idle(2);

        // Masked-off pending bit survives and is offered once unmasked
        step(8'h0C, 8'h08, 1'b0, 0, 1'b0);
        step(8'h00, 8'h08, 1'b0, 0, 1'b0);
        @(negedge clk);
        check("masked_pend_out", pend_out, 8'h08);
        step(8'h00, 8'h08, 1'b1, 6, 1'b0);
        @(negedge clk);
        check("bad_ack_pend_out", pend_out, 8'h08);
        check("bad_ack_irq_req", {7'b0, irq_req}, 8'h01);
        step(8'h00, 8'h08, 1'b1, 3, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 0, 1'b0);
        @(negedge clk);
        check("unmask_pend_out", pend_out, 8'h04);
        step(8'h00, 8'hFF, 1'b1, 2, 1'b0);
        step(8'h00, 8'hFF, 1'b1, 1, 1'b0);
        @(negedge clk);
        check("idle_ack_pend_out", pend_out, 8'h00);
        check("idle_ack_irq_req", {7'b0, irq_req}, 8'h00);

        // Overflow set, clear, and set-beats-clear
        step(8'h04, 8'hFF, 1'b0, 0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 0, 1'b0);
        step(8'h04, 8'hFF, 1'b0, 0, 1'b0);
        @(negedge clk);
        check("ovf_set", {7'b0, ovf}, 8'h01);
        step(8'h00, 8'hFF, 1'b0, 0, 1'b1);
        @(negedge clk);
        check("ovf_clr", {7'b0, ovf}, 8'h00);
        step(8'h04, 8'hFF, 1'b0, 0, 1'b1);
        @(negedge clk);
        check("ovf_set_beats_clr", {7'b0, ovf}, 8'h01);
        step(8'h00, 8'hFF, 1'b1, 2, 1'b1);
        idle(2);

        // Ack of line 4 coinciding with a new edge on line 4
        step(8'h10, 8'hFF, 1'b0, 0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 0, 1'b0);
        step(8'h10, 8'hFF, 1'b1, 4, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 0, 1'b0);
        @(negedge clk);
        check("set_wins_pend_out", pend_out, 8'h10);
        check("set_wins_irq_req", {7'b0, irq_req}, 8'h01);

        // Asynchronous reset in the middle of a handshake
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pend_out", pend_out, 8'h00);
        check("async_rst_irq_req", {7'b0, irq_req}, 8'h00);
        check("async_rst_ovf", {7'b0, ovf}, 8'h00);
        irq_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        rirq  = '0;
        rmask = 8'hFF;
        for (int t = 0; t < 2000; t++) begin
            rirq = rirq ^ (N'($urandom) & N'($urandom) & N'($urandom));
            if ($urandom_range(0, 15) == 0) rmask = N'($urandom);
            av = ($urandom_range(0, 9) < 3);
            ai = $urandom_range(0, N - 1);
            if (m_snap != '0 && $urandom_range(0, 3) != 0) begin
                for (int i = 0; i < N; i++)
                    if (m_snap[(ai + i) % N]) begin
                        ai = (ai + i) % N;
                        break;
                    end
            end
            step(rirq, rmask, av, ai, ($urandom_range(0, 9) == 0));
        end
        idle(2);
        @(negedge clk);
        check("sb_drained", N'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
